// File: rtl/axis_cpu_arb.sv
// ---- axis_cpu_arb : packet-level round-robin arbiter sharing one CPU stream ----
// ---- rev 1.0 : initial release                                              ----
`default_nettype none

module axis_cpu_arb #(
   parameter int N_SRC  = 4,
   parameter int TAG_AW = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [32*N_SRC-1:0]   src_TDATA,
   input  logic [N_SRC-1:0]      src_TVALID,
   input  logic [N_SRC-1:0]      src_TLAST,
   output logic [N_SRC-1:0]      src_TREADY,
   output logic [31:0]           cpu_din_TDATA,
   output logic                  cpu_din_TVALID,
   output logic                  cpu_din_TLAST,
   input  logic                  cpu_din_TREADY,
   input  logic [31:0]           cpu_dout_TDATA,
   input  logic                  cpu_dout_TVALID,
   input  logic                  cpu_dout_TLAST,
   output logic                  cpu_dout_TREADY,
   output logic [31:0]           dst_TDATA,
   output logic                  dst_TLAST,
   output logic [N_SRC-1:0]      dst_TVALID,
   input  logic [N_SRC-1:0]      dst_TREADY,
   output logic [TAG_AW:0]       pending
);

   localparam int IW    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int DEPTH = 1 << TAG_AW;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       grant_q, grant_d;
   logic [IW-1:0]       last_q, last_d;
   logic [IW-1:0]       rr_idx;
   logic [IW-1:0]       sel;
   logic                sel_found;
   logic [TAG_AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [TAG_AW:0]     count_q;
   logic [IW-1:0]       tag_mem_q [DEPTH];
   logic [IW-1:0]       head;
   logic                fifo_full, fifo_empty;
   logic                push, pop;
   logic [31:0]         src_data [N_SRC];

   generate
      for (genvar i = 0; i < N_SRC; i++) begin : g_src_unpack
         assign src_data[i] = src_TDATA[32*i +: 32];
      end
   endgenerate

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (TAG_AW+1)'(DEPTH));
   assign head       = tag_mem_q[rd_ptr_q];
   assign pending    = count_q;
   assign dst_TDATA  = cpu_dout_TDATA;
   assign dst_TLAST  = cpu_dout_TLAST;

   // Search starts just after the previous winner so every requester gets a turn.
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      rr_idx    = '0;
      for (int k = 1; k <= N_SRC; k++) begin
         rr_idx = IW'((int'(last_q) + k) % N_SRC);
         if (!sel_found && src_TVALID[rr_idx]) begin
            sel_found = 1'b1;
            sel       = rr_idx;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      last_d         = last_q;
      push           = 1'b0;
      src_TREADY     = '0;
      cpu_din_TVALID = 1'b0;
      cpu_din_TDATA  = src_data[grant_q];
      cpu_din_TLAST  = src_TLAST[grant_q];
      case (state_q)
         IDLE: begin
            if (sel_found && !fifo_full) begin
               state_d = BUSY;
               grant_d = sel;
               last_d  = sel;
               push    = 1'b1;
            end
         end
         BUSY: begin
            if (!rst) begin
               cpu_din_TVALID      = src_TVALID[grant_q];
               src_TREADY[grant_q] = cpu_din_TREADY;
            end
            if (src_TVALID[grant_q] && cpu_din_TREADY && src_TLAST[grant_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dst_TVALID      = '0;
      cpu_dout_TREADY = 1'b0;
      if (!fifo_empty && !rst) begin
         dst_TVALID[head] = cpu_dout_TVALID;
         cpu_dout_TREADY  = dst_TREADY[head];
      end
   end

   assign pop = cpu_dout_TVALID & cpu_dout_TREADY & cpu_dout_TLAST;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         last_q   <= IW'(N_SRC - 1);
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Tag storage needs no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (push && !rst) tag_mem_q[wr_ptr_q] <= sel;
   end

endmodule

`default_nettype wire

// File: tb/tb_axis_cpu_arb.sv
// ---- tb_axis_cpu_arb : directed + randomized check of axis_cpu_arb against a queue model ----
// ---- rev 1.0 : initial release                                                          ----
`default_nettype none

module tb_axis_cpu_arb;

   localparam int N     = 4;
   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;

   logic              clk = 1'b0;
   logic              rst;
   logic [32*N-1:0]   src_TDATA;
   logic [N-1:0]      src_TVALID, src_TLAST, src_TREADY;
   logic [31:0]       cpu_din_TDATA;
   logic              cpu_din_TVALID, cpu_din_TLAST, cpu_din_TREADY;
   logic [31:0]       cpu_dout_TDATA;
   logic              cpu_dout_TVALID, cpu_dout_TLAST, cpu_dout_TREADY;
   logic [31:0]       dst_TDATA;
   logic              dst_TLAST;
   logic [N-1:0]      dst_TVALID, dst_TREADY;
   logic [AW:0]       pending;

   axis_cpu_arb #(.N_SRC(N), .TAG_AW(AW)) dut (
      .clk(clk), .rst(rst),
      .src_TDATA(src_TDATA), .src_TVALID(src_TVALID), .src_TLAST(src_TLAST), .src_TREADY(src_TREADY),
      .cpu_din_TDATA(cpu_din_TDATA), .cpu_din_TVALID(cpu_din_TVALID), .cpu_din_TLAST(cpu_din_TLAST),
      .cpu_din_TREADY(cpu_din_TREADY),
      .cpu_dout_TDATA(cpu_dout_TDATA), .cpu_dout_TVALID(cpu_dout_TVALID), .cpu_dout_TLAST(cpu_dout_TLAST),
      .cpu_dout_TREADY(cpu_dout_TREADY),
      .dst_TDATA(dst_TDATA), .dst_TLAST(dst_TLAST), .dst_TVALID(dst_TVALID), .dst_TREADY(dst_TREADY),
      .pending(pending)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: which requester owns the CPU input, and the ordered list of owed results.
   bit m_valid = 1'b0;
   bit m_busy;
   int m_grant;
   int m_last;
   int m_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      logic [N-1:0] e_srdy, e_dv;
      logic         e_dinv, e_dordy;
      bit           full0, do_pop, do_push;
      int           sel;
      @(negedge clk);
      if (m_valid) begin
         e_srdy = '0; e_dinv = 1'b0; e_dv = '0; e_dordy = 1'b0;
         if (m_busy && !rst) begin
            e_dinv           = src_TVALID[m_grant];
            e_srdy[m_grant]  = cpu_din_TREADY;
            chk("din_data", cpu_din_TDATA, src_TDATA[32*m_grant +: 32]);
            chk("din_last", cpu_din_TLAST, src_TLAST[m_grant]);
         end
         if (m_q.size() > 0 && !rst) begin
            e_dv[m_q[0]] = cpu_dout_TVALID;
            e_dordy      = dst_TREADY[m_q[0]];
         end
         chk("src_ready", src_TREADY, e_srdy);
         chk("din_valid", cpu_din_TVALID, e_dinv);
         chk("dst_valid", dst_TVALID, e_dv);
         chk("dout_ready", cpu_dout_TREADY, e_dordy);
         chk("dst_data", dst_TDATA, cpu_dout_TDATA);
         chk("dst_last", dst_TLAST, cpu_dout_TLAST);
         chk("pending", pending, m_q.size());
      end
      if (rst) begin
         m_valid = 1'b1; m_busy = 1'b0; m_grant = 0; m_last = N - 1; m_q.delete();
      end else if (m_valid) begin
         full0   = (m_q.size() >= DEPTH);
         do_pop  = (m_q.size() > 0) && cpu_dout_TVALID && cpu_dout_TLAST && dst_TREADY[m_q[0]];
         do_push = 1'b0;
         sel     = -1;
         if (!m_busy) begin
            if (!full0) begin
               for (int k = 1; k <= N; k++) begin
                  if (sel < 0 && src_TVALID[(m_last + k) % N]) sel = (m_last + k) % N;
               end
            end
            if (sel >= 0) begin
               m_busy = 1'b1; m_grant = sel; m_last = sel; do_push = 1'b1;
            end
         end else if (src_TVALID[m_grant] && cpu_din_TREADY && src_TLAST[m_grant]) begin
            m_busy = 1'b0;
         end
         if (do_pop) void'(m_q.pop_front());
         if (do_push) m_q.push_back(sel);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      src_TDATA = '0; src_TVALID = '0; src_TLAST = '0; cpu_din_TREADY = 1'b0;
      cpu_dout_TDATA = '0; cpu_dout_TVALID = 1'b0; cpu_dout_TLAST = 1'b0; dst_TREADY = '0;
   endtask

   task automatic do_reset();
      quiet();
      rst = 1'b1;
      cycle(); cycle();
      rst = 1'b0;
   endtask

   int gnt_idx[$];
   int gnt_cyc[$];
   int acc;
   int ngrant;

   initial begin
      rst = 1'b1;
      quiet();
      do_reset();
      #1;
      chk("lit_rst_pending", pending, 0);
      chk("lit_rst_srdy", src_TREADY, 0);
      chk("lit_rst_doutrdy", cpu_dout_TREADY, 0);

      // Single packet from src1, 3 beats, then a 2-beat result.
      src_TVALID = 4'b0010; src_TDATA[63:32] = 32'h11; cpu_din_TREADY = 1'b1;
      #1;
      chk("lit_pkt_idle_dinv", cpu_din_TVALID, 0);
      cycle();
      #1;
      chk("lit_pkt_srdy", src_TREADY, 4'b0010);
      chk("lit_pkt_data", cpu_din_TDATA, 32'h11);
      chk("lit_pkt_pending", pending, 1);
      cycle();
      src_TDATA[63:32] = 32'h22; cycle();
      src_TDATA[63:32] = 32'h33; src_TLAST = 4'b0010; cycle();
      src_TVALID = '0; src_TLAST = '0;
      cpu_dout_TVALID = 1'b1; cpu_dout_TDATA = 32'hAA; dst_TREADY = 4'b0010;
      #1;
      chk("lit_ret_dstv", dst_TVALID, 4'b0010);
      chk("lit_ret_rdy", cpu_dout_TREADY, 1);
      cycle();
      cpu_dout_TDATA = 32'hBB; cpu_dout_TLAST = 1'b1; cycle();
      cpu_dout_TVALID = 1'b0; cpu_dout_TLAST = 1'b0;
      #1;
      chk("lit_ret_pending", pending, 0);

      // Fairness: every source always valid with single-beat packets.
      do_reset();
      src_TVALID = '1; src_TLAST = '1; cpu_din_TREADY = 1'b1;
      cpu_dout_TVALID = 1'b1; cpu_dout_TLAST = 1'b1; dst_TREADY = '1;
      for (int c = 0; c < 10; c++) begin
         #1;
         for (int i = 0; i < N; i++) if (src_TREADY[i]) begin gnt_idx.push_back(i); gnt_cyc.push_back(c); end
         cycle();
      end
      chk("lit_fair_count", gnt_idx.size(), 5);
      if (gnt_idx.size() == 5) begin
         chk("lit_fair_g0", gnt_idx[0], 0);
         chk("lit_fair_g1", gnt_idx[1], 1);
         chk("lit_fair_g2", gnt_idx[2], 2);
         chk("lit_fair_g3", gnt_idx[3], 3);
         chk("lit_fair_g4", gnt_idx[4], 0);
         chk("lit_fair_gap", gnt_cyc[1] - gnt_cyc[0], 2);
      end

      // Backpressure on the result stream for src3.
      do_reset();
      src_TVALID = 4'b1000; src_TLAST = 4'b1000; cpu_din_TREADY = 1'b1;
      cycle(); cycle();
      src_TVALID = '0; src_TLAST = '0;
      acc = 0;
      cpu_dout_TVALID = 1'b1; cpu_dout_TDATA = 32'hC1; dst_TREADY = 4'b1000;
      #1; if (cpu_dout_TREADY) acc++;
      cycle();
      dst_TREADY = '0; cpu_dout_TDATA = 32'hC2;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("lit_bp_rdy", cpu_dout_TREADY, 0);
         chk("lit_bp_dstv", dst_TVALID, 4'b1000);
         if (cpu_dout_TREADY) acc++;
         cycle();
      end
      dst_TREADY = 4'b1000;
      #1; if (cpu_dout_TREADY) acc++;
      cycle();
      cpu_dout_TDATA = 32'hC3; cpu_dout_TLAST = 1'b1;
      #1; if (cpu_dout_TREADY) acc++;
      cycle();
      quiet();
      #1;
      chk("lit_bp_beats", acc, 3);
      chk("lit_bp_pending", pending, 0);

      // Tag FIFO fills; no ninth grant until a result completes.
      do_reset();
      src_TVALID = '1; src_TLAST = '1; cpu_din_TREADY = 1'b1;
      ngrant = 0;
      for (int c = 0; c < 20; c++) begin
         #1; if (src_TREADY != 0) ngrant++;
         cycle();
      end
      chk("lit_full_grants", ngrant, DEPTH);
      chk("lit_full_pending", pending, DEPTH);
      cpu_dout_TVALID = 1'b1; cpu_dout_TLAST = 1'b1; dst_TREADY = '1;
      cycle();
      cpu_dout_TVALID = 1'b0; cpu_dout_TLAST = 1'b0;
      #1;
      chk("lit_full_pend7", pending, DEPTH - 1);
      chk("lit_full_idle", src_TREADY, 0);
      cycle();
      #1;
      chk("lit_full_regrant", src_TREADY, 4'b0001);

      // Reset in the middle of a 4-beat packet from src2.
      do_reset();
      src_TVALID = 4'b0100; cpu_din_TREADY = 1'b1;
      cycle(); cycle(); cycle();
      rst = 1'b1;
      #1;
      chk("lit_mid_srdy", src_TREADY, 0);
      chk("lit_mid_dinv", cpu_din_TVALID, 0);
      cycle();
      rst = 1'b0; src_TVALID = 4'b0101;
      #1;
      chk("lit_mid_pending", pending, 0);
      chk("lit_mid_idle", src_TREADY, 0);
      cycle();
      #1;
      chk("lit_mid_src0", src_TREADY, 4'b0001);
      cycle();

      // Randomized traffic, checked every cycle against the model.
      for (int c = 0; c < 3000; c++) begin
         rst             = ($urandom_range(199) == 0);
         src_TVALID      = N'($urandom);
         src_TLAST       = N'($urandom) & N'($urandom);
         for (int i = 0; i < N; i++) src_TDATA[32*i +: 32] = $urandom;
         cpu_din_TREADY  = ($urandom_range(3) != 0);
         cpu_dout_TDATA  = $urandom;
         cpu_dout_TVALID = $urandom_range(1);
         cpu_dout_TLAST  = ($urandom_range(2) == 0);
         dst_TREADY      = N'($urandom);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/axis_cpu_arb.md
AXIS_CPU_ARB -- requirements
Module: axis_cpu_arb

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of requester streams sharing one axis_cpu (2..8).
REQ-002 SHALL have parameter TAG_AW, default 3, log2 depth of the return-tag FIFO (depth 2^TAG_AW).
REQ-003 SHALL have port clk, input, 1, the only clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port src_TDATA, input, 32*N_SRC, requester data; slice i is [32*i+31:32*i].
REQ-006 SHALL have ports src_TVALID and src_TLAST, input, N_SRC, and src_TREADY, output, N_SRC, one bit per requester.
REQ-007 SHALL have ports cpu_din_TDATA (output, 32), cpu_din_TVALID (output, 1), cpu_din_TLAST (output, 1) and cpu_din_TREADY (input, 1), driving the CPU din stream.
REQ-008 SHALL have ports cpu_dout_TDATA (input, 32), cpu_dout_TVALID (input, 1), cpu_dout_TLAST (input, 1) and cpu_dout_TREADY (output, 1), accepting the CPU dout stream.
REQ-009 SHALL have ports dst_TDATA (output, 32, shared) and dst_TLAST (output, 1, shared), dst_TVALID (output, N_SRC) and dst_TREADY (input, N_SRC), the per-requester result streams.
REQ-010 SHALL have port pending, output, TAG_AW+1, the current tag FIFO occupancy.

Function
REQ-011 SHALL arbitrate at packet granularity; a grant holds until the TLAST beat of the granted packet is accepted.
REQ-012 SHALL use an ingress FSM with states IDLE and BUSY.
REQ-013 In IDLE, if any src_TVALID is set and the tag FIFO is not full, SHALL select the first valid index, searching round-robin from last_grant+1 mod N_SRC; on the next cycle it SHALL enter BUSY with grant=that index and last_grant=that index.
REQ-014 SHALL push the granted index into the tag FIFO on the IDLE->BUSY transition cycle.
REQ-015 In IDLE, all src_TREADY SHALL be 0 and cpu_din_TVALID SHALL be 0.
REQ-016 In BUSY, SHALL connect cpu_din_TDATA/TVALID/TLAST combinationally to src[grant], and src_TREADY[grant] to cpu_din_TREADY; all other src_TREADY SHALL be 0.
REQ-017 In BUSY, on cpu_din_TVALID & cpu_din_TREADY & cpu_din_TLAST, SHALL return to IDLE; IDLE lasts at least one cycle, so the minimum inter-packet gap is 1 cycle.
REQ-018 With the tag FIFO full, SHALL stay in IDLE and issue no grant.
REQ-019 The egress path SHALL use the tag FIFO head as the destination index h, valid only when the FIFO is not empty.
REQ-020 When the FIFO is not empty: dst_TVALID[h] SHALL equal cpu_dout_TVALID, other dst_TVALID bits SHALL be 0, and cpu_dout_TREADY SHALL equal dst_TREADY[h].
REQ-021 When the FIFO is empty: cpu_dout_TREADY SHALL be 0 and all dst_TVALID SHALL be 0.
REQ-022 dst_TDATA and dst_TLAST SHALL be cpu_dout_TDATA and cpu_dout_TLAST, passed through combinationally.
REQ-023 SHALL pop the tag FIFO on an accepted cpu_dout beat with TLAST.
REQ-024 Contract: the CPU emits exactly one output packet per input packet, in order; the block does not check this.
REQ-025 On a simultaneous push and pop, occupancy SHALL be unchanged; a push while full SHALL be impossible per REQ-018.
REQ-026 FIFO pointers SHALL wrap modulo 2^TAG_AW.
REQ-027 pending SHALL reflect the registered occupancy, updated one cycle after a push or pop.
REQ-028 The block SHALL introduce zero data latency in BUSY and egress; the arbitration latency from src_TVALID rising in IDLE to the first possible beat SHALL be 1 cycle.

Reset
REQ-029 On rst, SHALL enter IDLE, clear grant, set last_grant=N_SRC-1 (so src 0 has first priority), and empty the FIFO with pending=0.
REQ-030 While rst is high and on the cycle after it falls: src_TREADY=0, cpu_din_TVALID=0, cpu_dout_TREADY=0, dst_TVALID=0.
REQ-031 A reset mid-packet SHALL abandon the packet without flushing; the remaining beats are re-arbitrated as a new packet.

Verification
REQ-032 Single packet: src1 sends 3 beats (0x11, 0x22, 0x33+TLAST) -> grant 1 cycle after TVALID; CPU returns 2 beats -> dst_TVALID[1] only; pending 1->0.
REQ-033 Fairness: src0..src3 all continuously valid, 1-beat packets -> grant order 0,1,2,3,0, with a 1-cycle IDLE gap between packets.
REQ-034 FIFO full: N_SRC=4, TAG_AW=1, cpu_dout_TREADY never given -> after 2 grants pending=2 and no third grant; 1 cycle after the first result TLAST is accepted, a third grant occurs.
REQ-035 Backpressure: dst_TREADY[h]=0 for 5 cycles during a result packet -> cpu_dout_TREADY=0 for those cycles; no beat lost or duplicated.
REQ-036 Reset mid-packet: rst asserted after beat 2 of 4 from src2 -> all outputs idle and pending=0; after release, src0 and src2 both valid -> src0 granted first.
